// File: rtl/rr_grant_arbiter_pkg.sv
// rtl/rr_grant_arbiter_pkg.sv - shared constants and state encoding for the round-robin grant arbiter
package rr_grant_arbiter_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;
    localparam int HOLD_W  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/onehot_dec_3to8.sv
// rtl/onehot_dec_3to8.sv - combinational 3-bit index to 8-bit one-hot decode
module onehot_dec_3to8
    import rr_grant_arbiter_pkg::*;
(
    input  logic [IDX_W-1:0]   idx_i,
    output logic [NUM_REQ-1:0] onehot_o
);

    assign onehot_o = NUM_REQ'(1) << idx_i;

endmodule

// File: rtl/rr_grant_arbiter.sv
// rtl/rr_grant_arbiter.sv - 8-way round-robin arbiter with registered one-hot grant and hold timeout
module rr_grant_arbiter
    import rr_grant_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [HOLD_W-1:0]  max_hold,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid,
    output logic               timeout
);

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]    last_idx_q, last_idx_d;
    logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic                grant_valid_q, grant_valid_d;
    logic                timeout_q, timeout_d;

    logic                win_found;
    logic [IDX_W-1:0]    win_idx;
    logic [NUM_REQ-1:0]  win_onehot;
    logic                held_req;
    logic                hold_last;

    // Circular search starting just after the previous winner; i == NUM_REQ wraps back to it.
    always_comb begin
        logic [IDX_W-1:0] cand;
        win_found = 1'b0;
        win_idx   = last_idx_q;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = last_idx_q + IDX_W'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    onehot_dec_3to8 u_dec (
        .idx_i    (win_idx),
        .onehot_o (win_onehot)
    );

    assign held_req  = req[grant_idx_q];
    assign hold_last = (max_hold != '0) && (cnt_q == max_hold - HOLD_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            last_idx_q    <= IDX_W'(NUM_REQ - 1);
            grant_idx_q   <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_idx_q    <= last_idx_d;
            grant_idx_q   <= grant_idx_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_found) state_d = GRANT;
            GRANT:   if (!held_req || hold_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d         = cnt_q;
        last_idx_d    = last_idx_q;
        grant_idx_d   = grant_idx_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        timeout_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_idx_d   = win_idx;
                    last_idx_d    = win_idx;
                    grant_d       = win_onehot;
                    grant_valid_d = 1'b1;
                    cnt_d         = '0;
                end else begin
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                end
            end
            GRANT: begin
                // A dropped request wins over a simultaneous timeout: no pulse in that case.
                if (!held_req) begin
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                end else if (hold_last) begin
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    timeout_d     = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                grant_d       = '0;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = grant_valid_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb/tb_rr_grant_arbiter.sv - self-checking bench for rr_grant_arbiter
module tb_rr_grant_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] max_hold = 8'h00;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    rr_grant_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .max_hold    (max_hold),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    // Model: who owns the resource, how many cycles it has shown, who won last.
    logic [7:0] m_grant;
    int         m_idx;
    bit         m_valid;
    bit         m_to;
    bit         m_busy;
    int         m_owner;
    int         m_last;
    int         m_held;

    function automatic int pick(input logic [7:0] r, input int from);
        for (int k = 1; k <= 8; k++)
            if (r[(from + k) % 8]) return (from + k) % 8;
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_grant <= 8'h00; m_idx <= 0; m_valid <= 1'b0; m_to <= 1'b0;
            m_busy <= 1'b0; m_owner <= 0; m_last <= 7; m_held <= 0;
        end else if (!m_busy) begin
            m_to <= 1'b0;
            if (pick(req, m_last) >= 0) begin
                m_busy  <= 1'b1;
                m_owner <= pick(req, m_last);
                m_last  <= pick(req, m_last);
                m_idx   <= pick(req, m_last);
                m_grant <= 8'(1 << pick(req, m_last));
                m_valid <= 1'b1;
                m_held  <= 1;
            end else begin
                m_grant <= 8'h00; m_valid <= 1'b0;
            end
        end else if (!req[m_owner]) begin
            m_busy <= 1'b0; m_grant <= 8'h00; m_valid <= 1'b0; m_to <= 1'b0;
        end else if (max_hold != 0 && m_held == int'(max_hold)) begin
            m_busy <= 1'b0; m_grant <= 8'h00; m_valid <= 1'b0; m_to <= 1'b1;
        end else begin
            m_to <= 1'b0;
            if (m_held < 256) m_held <= m_held + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("model_grant", grant, m_grant);
            chk("model_grant_idx", grant_idx, m_idx);
            chk("model_grant_valid", grant_valid, m_valid);
            chk("model_timeout", timeout, m_to);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [7:0] rot_exp [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    logic [7:0] to_g    [11] = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h00, 8'h20, 8'h20, 8'h20, 8'h20, 8'h00, 8'h04};
    bit         to_t    [11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};

    initial begin
        int         seq[$];
        int         seen;
        logic [7:0] prev;

        reset = 1'b1; req = 8'hFF; max_hold = 8'd0;
        tick(); tick();
        chk("reset_grant", grant, 8'h00);
        chk("reset_idx", grant_idx, 0);
        chk("reset_valid", grant_valid, 0);
        chk("reset_timeout", timeout, 0);
        reset = 1'b0;
        checking = 1'b1;
        tick();
        chk("first_grant", grant, 8'h01);
        chk("first_idx", grant_idx, 0);
        chk("first_valid", grant_valid, 1);

        // Rotation: each winner releases after three granted cycles, then re-requests.
        seq.push_back(int'(grant));
        prev = grant;
        seen = 1;
        for (int c = 0; c < 80 && seq.size() < 9; c++) begin
            tick();
            if (grant != 8'h00) begin
                if (grant != prev) begin
                    chk("rot_bubble", prev, 8'h00);
                    seq.push_back(int'(grant));
                    seen = 0;
                end
                seen++;
                if (seen == 3) req[grant_idx] = 1'b0;
            end else begin
                req = 8'hFF;
            end
            prev = grant;
        end
        chk("rot_count", seq.size(), 9);
        for (int i = 0; i < 9; i++)
            if (i < seq.size()) chk("rot_seq", seq[i], rot_exp[i]);
        req = 8'h00;
        tick(); tick();
        chk("idle_grant", grant, 8'h00);

        req = 8'h24; max_hold = 8'd4;
        for (int i = 0; i < 11; i++) begin
            tick();
            chk("to_grant", grant, to_g[i]);
            chk("to_pulse", timeout, to_t[i]);
        end
        req = 8'h00; max_hold = 8'd0;
        tick(); tick();

        max_hold = 8'd2; req = 8'h08;
        tick();
        chk("sim_grant0", grant, 8'h08);
        tick();
        chk("sim_grant1", grant, 8'h08);
        req = 8'h00;
        tick();
        chk("sim_release", grant, 8'h00);
        chk("sim_no_timeout", timeout, 0);
        tick();
        chk("sim_no_timeout2", timeout, 0);

        max_hold = 8'd0; req = 8'h10;
        tick();
        chk("ar_grant", grant, 8'h10);
        tick();
        #1 reset = 1'b1;
        #1;
        chk("ar_grant_now", grant, 8'h00);
        chk("ar_valid_now", grant_valid, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("ar_regrant", grant, 8'h10);
        chk("ar_regrant_idx", grant_idx, 4);

        req = 8'h00;
        tick(); tick();
        req = 8'h08;
        tick();
        for (int i = 0; i < 20; i++) begin
            chk("single_grant", grant, 8'h08);
            chk("single_timeout", timeout, 0);
            tick();
        end

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
